// File: rtl/vga_frame_monitor_if.sv
// TinyQV register bus between the CPU side (master) and the VGA frame monitor (slave).
interface vga_frame_monitor_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (output address, data_in, data_write_n, data_read_n,
                    input  data_out, data_ready);
    modport slave  (input  address, data_in, data_write_n, data_read_n,
                    output data_out, data_ready);
endinterface

// File: rtl/vga_frame_monitor.sv
// Receives a TinyVGA PMOD stream, recovers line/frame timing, tracks lock and CRCs the active window.
// Optional pixel probe registers (0x14/0x18) are built when VGA_MON_PROBE_EN is defined.
module vga_frame_monitor #(
    parameter int H_START  = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 33,
    parameter int V_ACTIVE = 480,
    parameter int SYNC_POL = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          vga_in,
    vga_frame_monitor_if.slave  bus,
    output logic                user_interrupt
);
    typedef enum logic [1:0] {HUNT = 2'd0, MEASURE = 2'd1, VERIFY = 2'd2, LOCKED = 2'd3} state_t;

    localparam logic [11:0] HW_LO = 12'(H_START);
    localparam logic [11:0] HW_HI = 12'(H_START + H_ACTIVE);
    localparam logic [10:0] VW_LO = 11'(V_START);
    localparam logic [10:0] VW_HI = 11'(V_START + V_ACTIVE);

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    logic [7:0]  s1;
    logic [1:0]  s2;          // only the sync pair is needed from the second stage
    logic        vs1, hs1, vs2, hs2, vs_edge, hs_edge;
    logic [11:0] h_cnt, prev_period, line_len, close_period, ref_period;
    logic [10:0] line_cnt, close_lines, ref_lines;
    logic        first_line, line_err, line_mismatch, close_err, in_win;
    logic [15:0] crc;
    logic        en, irq_en, irq_pend, timeout;
    logic [11:0] h_period;
    logic [10:0] v_lines;
    logic [15:0] frame_crc, frame_count;
    logic        frame_close, timeout_hit, ref_load, match, wr_en, ctrl_wr;
    state_t      state_q, state_d;
    logic [31:0] rdata;

    assign vs1 = (SYNC_POL != 0) ? s1[7] : ~s1[7];
    assign hs1 = (SYNC_POL != 0) ? s1[6] : ~s1[6];
    assign vs2 = (SYNC_POL != 0) ? s2[1] : ~s2[1];
    assign hs2 = (SYNC_POL != 0) ? s2[0] : ~s2[0];
    assign vs_edge = vs1 & ~vs2;
    assign hs_edge = hs1 & ~hs2;

    assign line_len      = h_cnt + 12'd1;
    assign line_mismatch = hs_edge & ~first_line & (line_len != prev_period);
    // A coincident hsync edge closes the last line of the frame that is ending.
    assign close_period  = hs_edge ? line_len : prev_period;
    assign close_lines   = line_cnt + 11'd1;
    assign close_err     = line_err | line_mismatch;
    assign in_win = (h_cnt >= HW_LO) && (h_cnt < HW_HI) && (line_cnt >= VW_LO) && (line_cnt < VW_HI);

    assign frame_close = en & vs_edge;
    assign timeout_hit = en & ~hs_edge & (h_cnt == 12'd4094);
    assign match       = (close_period == ref_period) && (close_lines == ref_lines) && !close_err;

    assign wr_en   = (bus.data_write_n != 2'b11);
    assign ctrl_wr = wr_en && (bus.address == 6'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= vga_in;
            s2 <= s1[7:6];
        end
    end

    // Timing counters, line check and CRC are held at their reset values while disabled.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            h_cnt       <= '0;
            line_cnt    <= '0;
            prev_period <= '0;
            first_line  <= 1'b1;
            line_err    <= 1'b0;
            crc         <= 16'hFFFF;
            ref_period  <= '0;
            ref_lines   <= '0;
        end else begin
            if (hs_edge)               h_cnt <= '0;
            else if (h_cnt != 12'hFFF) h_cnt <= h_cnt + 12'd1;
            if (vs_edge)      line_cnt <= '0;
            else if (hs_edge) line_cnt <= line_cnt + 11'd1;
            if (hs_edge) prev_period <= line_len;
            if (vs_edge)      first_line <= 1'b1;
            else if (hs_edge) first_line <= 1'b0;
            if (vs_edge)            line_err <= 1'b0;
            else if (line_mismatch) line_err <= 1'b1;
            if (vs_edge)     crc <= 16'hFFFF;
            else if (in_win) crc <= crc_byte(crc, {2'b00, s1[5:0]});
            if (ref_load) begin
                ref_period <= close_period;
                ref_lines  <= close_lines;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= HUNT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ref_load = 1'b0;
        if (!en || timeout_hit) begin
            state_d = HUNT;
        end else if (vs_edge) begin
            unique case (state_q)
                HUNT:    state_d = MEASURE;
                MEASURE: begin ref_load = 1'b1; state_d = VERIFY; end
                VERIFY:  if (match) state_d = LOCKED; else ref_load = 1'b1;
                LOCKED:  if (!match) begin ref_load = 1'b1; state_d = VERIFY; end
                default: state_d = HUNT;
            endcase
        end
    end

    // Latched frame results and control survive EN=0; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            en          <= 1'b0;
            irq_en      <= 1'b0;
            irq_pend    <= 1'b0;
            timeout     <= 1'b0;
            h_period    <= '0;
            v_lines     <= '0;
            frame_crc   <= '0;
            frame_count <= '0;
        end else begin
            if (ctrl_wr) begin
                en     <= bus.data_in[0];
                irq_en <= bus.data_in[1];
            end
            if (frame_close) begin
                h_period    <= close_period;
                v_lines     <= close_lines;
                frame_crc   <= crc;
                frame_count <= frame_count + 16'd1;
            end
            if (frame_close && irq_en)         irq_pend <= 1'b1;
            else if (ctrl_wr && bus.data_in[2]) irq_pend <= 1'b0;
            if (timeout_hit)                    timeout <= 1'b1;
            else if (ctrl_wr && bus.data_in[3]) timeout <= 1'b0;
        end
    end

`ifdef VGA_MON_PROBE_EN
    logic [11:0] probe_x, win_x;
    logic [10:0] probe_y, win_y;
    logic [5:0]  probe_pix;
    logic        probe_vld;

    assign win_x = h_cnt - HW_LO;
    assign win_y = line_cnt - VW_LO;

    always_ff @(posedge clk) begin
        if (reset) begin
            probe_x   <= '0;
            probe_y   <= '0;
            probe_pix <= '0;
            probe_vld <= 1'b0;
        end else if (wr_en && bus.address == 6'h14) begin
            probe_x   <= bus.data_in[11:0];
            probe_y   <= bus.data_in[26:16];
            probe_vld <= 1'b0;
        end else if (en && in_win && win_x == probe_x && win_y == probe_y) begin
            probe_pix <= s1[5:0];
            probe_vld <= 1'b1;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (bus.address)
            6'h00: rdata = {26'd0, state_q, timeout, irq_pend, irq_en, en};
            6'h04: rdata = {20'd0, h_period};
            6'h08: rdata = {21'd0, v_lines};
            6'h0C: rdata = {16'd0, frame_crc};
            6'h10: rdata = {16'd0, frame_count};
`ifdef VGA_MON_PROBE_EN
            6'h14: rdata = {5'd0, probe_y, 4'd0, probe_x};
            6'h18: rdata = {24'd0, probe_vld, 1'b0, probe_pix};
`endif
            default: rdata = '0;
        endcase
    end

    assign bus.data_out   = rdata;
    assign bus.data_ready = 1'b1;
    assign user_interrupt = irq_pend;

    // Reads are combinational, so the read strobe and upper write bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{bus.data_in[31:4], bus.data_read_n};
endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor: a free-running VGA generator feeds a CRC scoreboard.
module tb_vga_frame_monitor;
    localparam int LINE = 20;
    localparam int LINES = 10;

    typedef struct packed {
        logic [15:0] crc;
        logic [11:0] hp;
        logic [10:0] vl;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] vga_in = 8'h00;
    logic       user_interrupt;

    vga_frame_monitor_if bus();

    vga_frame_monitor #(
        .H_START(2), .H_ACTIVE(8), .V_START(1), .V_ACTIVE(4), .SYNC_POL(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vga_in(vga_in),
        .bus(bus),
        .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    int gen_x = 0, gen_y = 0, gen_frames = 0, gen_pat = 0, cur_pat = 0, cur_len = LINE;
    bit gen_run = 0, gen_started = 0, stretch_req = 0;

    function automatic logic [5:0] pix(int pat, int x, int y);
        case (pat)
            0:       return 6'h00;
            1:       return 6'h3F;
            default: return 6'((x * 7 + y * 3 + pat) % 64);
        endcase
    endfunction

    // Bit-serial CRC-16-CCITT over the window: lines 1..4, line offsets 3..10 after the hsync edge.
    function automatic logic [15:0] model_crc(int pat);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        for (int y = 1; y <= 4; y++)
            for (int x = 3; x <= 10; x++) begin
                b = {2'b00, pix(pat, x, y)};
                for (int i = 7; i >= 0; i--) begin
                    fb = c[15] ^ b[i];
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                end
            end
        return c;
    endfunction

    // Generator: vsync and hsync rise together on line 0 offset 0; hsync 3 cycles, vsync 2 lines.
    always @(negedge clk) begin
        if (!gen_run) begin
            vga_in      = 8'h00;
            gen_x       = 0;
            gen_y       = 0;
            gen_started = 0;
        end else begin
            if (gen_x == 0 && gen_y == 0) begin
                if (gen_started) sb.push_back('{crc: model_crc(cur_pat), hp: 12'd20, vl: 11'd10});
                gen_started = 1;
                cur_pat     = gen_pat;
                gen_frames++;
            end
            if (gen_x == 0) begin
                cur_len = (stretch_req && gen_y == 3) ? LINE + 1 : LINE;
                if (cur_len != LINE) stretch_req = 0;
            end
            vga_in = {gen_y < 2, gen_x < 3, pix(cur_pat, gen_x, gen_y)};
            gen_x++;
            if (gen_x == cur_len) begin
                gen_x = 0;
                gen_y = (gen_y == LINES - 1) ? 0 : gen_y + 1;
            end
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(logic [5:0] a, logic [31:0] d);
        @(negedge clk);
        bus.address      = a;
        bus.data_in      = d;
        bus.data_write_n = 2'b10;
        @(negedge clk);
        bus.data_write_n = 2'b11;
    endtask

    task automatic rd(logic [5:0] a, output logic [31:0] d);
        bus.address     = a;
        bus.data_read_n = 2'b00;
        #1;
        d = bus.data_out;
        bus.data_read_n = 2'b11;
    endtask

    // Returns just after the first posedge that sampled a new frame start from the generator.
    task automatic wait_sof();
        int f0 = gen_frames;
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (gen_frames != f0) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sof_wait: observed no frame start, expected one within 600 cycles");
        end
    endtask

    task automatic after_close();
        wait_sof();
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_check(string tag, logic [31:0] exp_status);
        exp_t        e;
        logic [31:0] d;
        after_close();
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_sb: observed empty scoreboard, expected one entry", tag);
        end else begin
            e = sb.pop_front();
            rd(6'h0C, d); chk({tag, "_crc"}, d, {16'd0, e.crc});
            rd(6'h04, d); chk({tag, "_hper"}, d, {20'd0, e.hp});
            rd(6'h08, d); chk({tag, "_vlines"}, d, {21'd0, e.vl});
        end
        rd(6'h00, d); chk({tag, "_status"}, d, exp_status);
    endtask

    logic [31:0] d, crc0, crc1;

    initial begin
        bus.address      = 6'h00;
        bus.data_in      = 32'h0;
        bus.data_write_n = 2'b11;
        bus.data_read_n  = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        rd(6'h00, d); chk("rst_status", d, 32'h0);
        rd(6'h0C, d); chk("rst_crc", d, 32'h0);
        rd(6'h10, d); chk("rst_count", d, 32'h0);
        chk("rst_irq", {31'd0, user_interrupt}, 32'h0);

        // Acquire lock on clean 20x10 frames of black.
        wr(6'h00, 32'h01);
        gen_pat = 0;
        gen_run = 1;
        after_close();
        rd(6'h00, d); chk("f1_status", d, 32'h11);
        frame_check("f2", 32'h21);
        frame_check("f3", 32'h31);
        rd(6'h10, d); chk("f3_count", d, 32'd3);
        rd(6'h0C, crc0);

        // All-0x3F and gradient frames, each repeated.
        gen_pat = 1;
        frame_check("f4", 32'h31);
        frame_check("white1", 32'h31);
        rd(6'h0C, crc1);
        frame_check("white2", 32'h31);
        n_cmp++;
        assert (crc0 !== crc1) else begin
            n_bad++;
            $error("FAIL crc_differ: observed black 0x%0h white 0x%0h, expected different", crc0, crc1);
        end
        gen_pat = 2;
        frame_check("white3", 32'h31);
        frame_check("grad1", 32'h31);

        // One 21-cycle line drops lock, a clean frame regains it.
        stretch_req = 1;
        frame_check("grad2_long", 32'h21);
        frame_check("relock1", 32'h31);
        frame_check("relock2", 32'h31);

        // Stall the stream until h_cnt saturates.
        gen_run = 0;
        repeat (4200) @(negedge clk);
        rd(6'h00, d); chk("timeout_status", d, 32'h09);
        wr(6'h00, 32'h09);
        rd(6'h00, d); chk("timeout_clr", d, 32'h01);

        // Interrupt: set on frame close, set beats a coincident clear.
        wr(6'h00, 32'h03);
        gen_run = 1;
        after_close();
        chk("irq_set", {31'd0, user_interrupt}, 32'h1);
        rd(6'h00, d); chk("irq_status", d, 32'h17);
        wait_sof();
        wr(6'h00, 32'h07);
        chk("irq_set_wins", {31'd0, user_interrupt}, 32'h1);
        rd(6'h00, d); chk("irq_win_status", d, 32'h27);
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            rd(6'h0C, d); chk("irq_frame_crc", d, {16'd0, e.crc});
        end
        repeat (20) @(negedge clk);
        wr(6'h00, 32'h07);
        chk("irq_cleared", {31'd0, user_interrupt}, 32'h0);
        rd(6'h00, d); chk("irq_clr_status", d, 32'h23);

        // Reset at line 5 discards the partial frame.
        wait_sof();
        repeat (5 * LINE) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd(6'h00, d); chk("mid_rst_status", d, 32'h0);
        rd(6'h04, d); chk("mid_rst_hper", d, 32'h0);
        rd(6'h08, d); chk("mid_rst_vlines", d, 32'h0);
        rd(6'h0C, d); chk("mid_rst_crc", d, 32'h0);
        rd(6'h10, d); chk("mid_rst_count", d, 32'h0);
        chk("mid_rst_irq", {31'd0, user_interrupt}, 32'h0);
        wr(6'h00, 32'h01);
        sb.delete();
        after_close();
        rd(6'h10, d); chk("post_rst_count", d, 32'd1);
        rd(6'h00, d); chk("post_rst_status", d, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
